// File: rtl/hc194_pkg.sv
// Shared encodings for the hc194 command sequencer: opcodes, hc194 mode pins and FSM states.
package hc194_pkg;

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_SHR   = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_CLEAR = 3'b100;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  function automatic logic op_reserved(input logic [2:0] op);
    return op > OP_CLEAR;
  endfunction

endpackage

// File: rtl/hc194_model.sv
// Cycle-level model of the hc194 4-bit universal shift register, driven by its pin values.
module hc194_model
  import hc194_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       mrn,
  input  logic       s1,
  input  logic       s0,
  input  logic       dsr,
  input  logic       dsl,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] q_reg;

  always_ff @(posedge clk) begin
    if (srst || !mrn) begin
      q_reg <= 4'b0000;
    end else begin
      case ({s1, s0})
        MODE_SHR:  q_reg <= {q_reg[2:0], dsr};
        MODE_SHL:  q_reg <= {dsl, q_reg[3:1]};
        MODE_LOAD: q_reg <= d;
        default:   q_reg <= q_reg;
      endcase
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/hc194_seq.sv
// Command sequencer driving an hc194: one command per handshake, registered pins,
// and a cycle-exact shadow of the register contents in q_model.
module hc194_seq
  import hc194_pkg::*;
#(
  parameter int MAX_SHIFT = 8,
  parameter int CNT_W     = 4
) (
  input  logic                 CP,
  input  logic                 MR,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [3:0]           cmd_data,
  input  logic [MAX_SHIFT-1:0] cmd_sdata,
  input  logic [CNT_W-1:0]     cmd_cnt,
  output logic                 S1,
  output logic                 S0,
  output logic                 D0,
  output logic                 D1,
  output logic                 D2,
  output logic                 D3,
  output logic                 DSR,
  output logic                 DSL,
  output logic                 MRN,
  output logic [3:0]           q_model,
  output logic                 done,
  output logic                 err
);

  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_SHIFT);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [CNT_W-1:0]     n_reg, n_next;
  logic [1:0]           dir_reg, dir_next;
  logic [MAX_SHIFT-1:0] sdata_reg, sdata_next;
  logic                 err_pend_reg, err_pend_next;
  logic [1:0]           s_reg, s_next;
  logic [3:0]           d_reg, d_next;
  logic                 dsr_reg, dsr_next;
  logic                 dsl_reg, dsl_next;
  logic                 mrn_reg, mrn_next;
  logic                 done_reg, done_next;
  logic                 err_reg, err_next;
  logic                 ready_reg, ready_next;

  logic [CNT_W-1:0]     n_sat;
  logic [CNT_W-1:0]     step_idx;
  logic [MAX_SHIFT-1:0] sdata_shifted;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    n_next        = n_reg;
    dir_next      = dir_reg;
    sdata_next    = sdata_reg;
    err_pend_next = err_pend_reg;
    s_next        = s_reg;
    d_next        = d_reg;
    dsr_next      = dsr_reg;
    dsl_next      = dsl_reg;
    mrn_next      = mrn_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;

    n_sat = (cmd_cnt > MAX_N) ? MAX_N : cmd_cnt;
    // cnt_reg marks the step currently on the pins; the following step uses bit n-cnt.
    step_idx      = n_reg - cnt_reg;
    sdata_shifted = sdata_reg >> step_idx;

    case (state_reg)
      ST_IDLE: begin
        s_next   = MODE_HOLD;
        mrn_next = 1'b1;
        if (cmd_valid && ready_reg) begin
          state_next    = ST_EXEC;
          sdata_next    = cmd_sdata;
          err_pend_next = op_reserved(cmd_op);
          cnt_next      = '0;
          n_next        = CNT_W'(1);
          dir_next      = MODE_HOLD;
          case (cmd_op)
            OP_SHR, OP_SHL: begin
              // A zero count degrades to a single hold step.
              if (cmd_cnt != '0) begin
                n_next   = n_sat;
                cnt_next = n_sat - CNT_W'(1);
                if (cmd_op == OP_SHR) begin
                  dir_next = MODE_SHR;
                  s_next   = MODE_SHR;
                  dsr_next = cmd_sdata[0];
                end else begin
                  dir_next = MODE_SHL;
                  s_next   = MODE_SHL;
                  dsl_next = cmd_sdata[0];
                end
              end
            end
            OP_LOAD: begin
              s_next = MODE_LOAD;
              d_next = cmd_data;
            end
            OP_CLEAR: mrn_next = 1'b0;
            default: ;
          endcase
        end
      end
      ST_EXEC: begin
        if (cnt_reg == '0) begin
          state_next = ST_IDLE;
          s_next     = MODE_HOLD;
          mrn_next   = 1'b1;
          done_next  = 1'b1;
          err_next   = err_pend_reg;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
          if (dir_reg == MODE_SHR) begin
            dsr_next = sdata_shifted[0];
          end else begin
            dsl_next = sdata_shifted[0];
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    ready_next = (state_next == ST_IDLE);
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      n_reg        <= '0;
      dir_reg      <= MODE_HOLD;
      sdata_reg    <= '0;
      err_pend_reg <= 1'b0;
      s_reg        <= MODE_HOLD;
      d_reg        <= 4'b0000;
      dsr_reg      <= 1'b0;
      dsl_reg      <= 1'b0;
      mrn_reg      <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      n_reg        <= n_next;
      dir_reg      <= dir_next;
      sdata_reg    <= sdata_next;
      err_pend_reg <= err_pend_next;
      s_reg        <= s_next;
      d_reg        <= d_next;
      dsr_reg      <= dsr_next;
      dsl_reg      <= dsl_next;
      mrn_reg      <= mrn_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      ready_reg    <= ready_next;
    end
  end

  // The shadow sees exactly the registered pins the real hc194 sees.
  hc194_model u_model (
    .clk  (CP),
    .srst (MR),
    .mrn  (mrn_reg),
    .s1   (s_reg[1]),
    .s0   (s_reg[0]),
    .dsr  (dsr_reg),
    .dsl  (dsl_reg),
    .d    (d_reg),
    .q    (q_model)
  );

  assign cmd_ready = ready_reg;
  assign S1        = s_reg[1];
  assign S0        = s_reg[0];
  assign D0        = d_reg[0];
  assign D1        = d_reg[1];
  assign D2        = d_reg[2];
  assign D3        = d_reg[3];
  assign DSR       = dsr_reg;
  assign DSL       = dsl_reg;
  assign MRN       = mrn_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_hc194_seq.sv
// Scoreboard bench for hc194_seq: per-command expectations from a behavioural model,
// checked by an independent monitor on done, plus per-step pin checks and a pin-driven hc194.
module tb_hc194_seq;
  import hc194_pkg::*;

  localparam int MAX_SHIFT = 8;
  localparam int CNT_W     = 4;

  logic                 CP = 1'b0;
  logic                 MR = 1'b1;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [2:0]           cmd_op = 3'd0;
  logic [3:0]           cmd_data = 4'd0;
  logic [MAX_SHIFT-1:0] cmd_sdata = '0;
  logic [CNT_W-1:0]     cmd_cnt = '0;
  logic S1, S0, D0, D1, D2, D3, DSR, DSL, MRN, done, err;
  logic [3:0] q_model;
  logic [3:0] ref_q;

  always #5 CP = ~CP;

  hc194_seq #(.MAX_SHIFT(MAX_SHIFT), .CNT_W(CNT_W)) dut (
    .CP(CP), .MR(MR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_sdata(cmd_sdata), .cmd_cnt(cmd_cnt),
    .S1(S1), .S0(S0), .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .DSR(DSR), .DSL(DSL), .MRN(MRN), .q_model(q_model), .done(done), .err(err)
  );

  // Stand-in for the physical hc194, fed only by the sequencer's pins.
  hc194_model u_ref (
    .clk(CP), .srst(1'b0), .mrn(MRN), .s1(S1), .s0(S0),
    .dsr(DSR), .dsl(DSL), .d({D3, D2, D1, D0}), .q(ref_q)
  );

  typedef struct {
    logic [3:0] q;
    logic       err;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         rst_edges = 0;
  bit         mon_en = 0;
  logic [3:0] exp_q = 4'b0000;

  always @(posedge CP) begin
    cyc       <= cyc + 1;
    rst_edges <= MR ? rst_edges + 1 : 0;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse; also tracks the pin-driven hc194.
  always @(negedge CP) begin
    if (mon_en) begin
      // The pin-driven register clears one edge late when a reset first hits.
      if (rst_edges != 1) check("ref_q_vs_q_model", q_model, ref_q);
      if (done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", done, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_q", q_model, e.q);
          check("done_err", err, e.err);
          check("done_cycle", cyc, e.due);
          $display("txn done cyc=%0d q=%b err=%b (want q=%b err=%b)", cyc, q_model, err, e.q, e.err);
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] data,
                      input logic [MAX_SHIFT-1:0] sdata, input logic [CNT_W-1:0] cnt);
    int         n;
    int         w;
    int         c0;
    logic [3:0] nq;
    logic       e_err;
    logic [1:0] mode;
    bit         shifting;

    e_err    = (op > 3'd4);
    shifting = ((op == OP_SHR) || (op == OP_SHL)) && (cnt != 0);
    n        = 1;
    if (shifting) n = (int'(cnt) > MAX_SHIFT) ? MAX_SHIFT : int'(cnt);
    nq = exp_q;
    if (op == OP_LOAD)  nq = data;
    if (op == OP_CLEAR) nq = 4'b0000;
    if (shifting) begin
      for (int i = 0; i < n; i++) begin
        if (op == OP_SHR) nq = {nq[2:0], sdata[i]};
        else              nq = {sdata[i], nq[3:1]};
      end
    end
    mode = 2'b00;
    if (op == OP_LOAD) mode = 2'b11;
    if (shifting)      mode = (op == OP_SHR) ? 2'b01 : 2'b10;

    cmd_op = op; cmd_data = data; cmd_sdata = sdata; cmd_cnt = cnt; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge CP);
      w++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge CP);
    #1;
    c0 = cyc;
    sb.push_back('{q: nq, err: e_err, due: c0 + n});
    exp_q = nq;
    $display("txn issue cyc=%0d op=%0d data=%b sdata=%b cnt=%0d steps=%0d", c0, op, data, sdata, cnt, n);
    for (int i = 0; i < n; i++) begin
      @(negedge CP);
      if (i == 0) begin
        // Scramble the command bus while busy; the sequencer must ignore it.
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = 4'($urandom);
        cmd_sdata = MAX_SHIFT'($urandom);
        cmd_cnt   = CNT_W'($urandom);
      end
      check("step_mode", {S1, S0}, mode);
      check("step_mrn", MRN, (op == OP_CLEAR) ? 1'b0 : 1'b1);
      check("step_ready", cmd_ready, 1'b0);
      if (op == OP_LOAD) check("step_d", {D3, D2, D1, D0}, data);
      if (shifting && op == OP_SHR) check("step_dsr", DSR, sdata[i]);
      if (shifting && op == OP_SHL) check("step_dsl", DSL, sdata[i]);
    end
  endtask

  initial begin
    int w;
    // T1: reset
    @(negedge CP);
    @(negedge CP);
    check("rst_mrn", MRN, 1'b0);
    check("rst_mode", {S1, S0}, 2'b00);
    check("rst_q", q_model, 4'b0000);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_done", done, 1'b0);
    MR = 1'b0;
    mon_en = 1;
    @(negedge CP);
    check("post_rst_mrn", MRN, 1'b1);
    check("post_rst_ready", cmd_ready, 1'b1);

    // T2-T5 directed
    send(OP_LOAD,  4'b1010, 8'h00, 4'd0);
    send(OP_CLEAR, 4'b0000, 8'h00, 4'd0);
    send(OP_SHR,   4'b0000, 8'b0000_0101, 4'd3);
    send(OP_LOAD,  4'b1010, 8'h00, 4'd0);
    send(OP_SHL,   4'b0000, 8'b0000_0011, 4'd2);
    send(OP_SHR,   4'b0000, 8'hFF, 4'd0);
    send(OP_SHL,   4'b0000, 8'b1011_0110, 4'd15);
    send(3'b111,   4'b0101, 8'hA5, 4'd4);
    send(OP_LOAD,  4'b1111, 8'h00, 4'd0);
    send(OP_CLEAR, 4'b0000, 8'h00, 4'd0);
    send(OP_HOLD,  4'b0000, 8'h00, 4'd0);

    // Randomized commands
    for (int k = 0; k < 40; k++) begin
      send(3'($urandom_range(0, 7)), 4'($urandom), MAX_SHIFT'($urandom), CNT_W'($urandom));
    end

    // T6: reset during step 2 of a 5-step shift right
    send(OP_LOAD, 4'b0110, 8'h00, 4'd0);
    cmd_op = OP_SHR; cmd_data = 4'b0; cmd_sdata = 8'b0001_1011; cmd_cnt = 4'd5; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge CP);
      w++;
    end
    check("abort_accept", cmd_ready, 1'b1);
    @(posedge CP);
    #1;
    cmd_valid = 1'b0;
    @(negedge CP);
    @(negedge CP);
    MR = 1'b1;
    @(negedge CP);
    check("abort_done", done, 1'b0);
    check("abort_q", q_model, 4'b0000);
    check("abort_mrn", MRN, 1'b0);
    check("abort_mode", {S1, S0}, 2'b00);
    check("abort_ready", cmd_ready, 1'b0);
    @(negedge CP);
    MR = 1'b0;
    exp_q = 4'b0000;
    send(OP_SHR, 4'b0000, 8'b0000_0001, 4'd1);

    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge CP);
      w++;
    end
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
